// File: rtl/instr_dispatcher.sv
// instr_dispatcher: in-order issue of accelerator instructions to the
// weight, matrix and activation units with dependency and sync waits.
`timescale 1ns/1ps
module instr_dispatcher #(
  parameter int                 CNT_W      = 32,
  parameter int                 INSTR_W    = 32,
  parameter logic [INSTR_W-1:0] INIT_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [INSTR_W-1:0] lab_instr,
  input  logic               lab_valid,
  output logic               lab_busy,
  input  logic               wt_busy,
  input  logic               mm_busy,
  input  logic               act_busy,
  output logic               wt_en,
  output logic               mm_en,
  output logic               act_en,
  output logic [INSTR_W-1:0] unit_instr,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ALL,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    C_HALT,
    C_SYNC,
    C_NOP,
    C_WT,
    C_MM,
    C_ACT,
    C_ILL
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t             state;
  logic [INSTR_W-1:0] held;
  logic [7:0]         op;
  cls_t               cls;
  logic               wt_blk;
  logic               mm_blk;
  logic               act_blk;
  logic               wt_free;
  logic               mm_free;
  logic               act_free;
  logic               all_free;

  assign op = held[INSTR_W-1 -: 8];

  // Classify the held opcode; the HALT encoding is carved out of WEIGHT
  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      (op == 8'hFF):                  cls = C_HALT;
      (op == 8'h01):                  cls = C_SYNC;
      (op == 8'h00):                  cls = C_NOP;
      (op[7] && (op != 8'hFF)):       cls = C_WT;
      (op[7:5] == 3'b001):            cls = C_MM;
      (op[7:3] == 5'b00001):          cls = C_ACT;
      default:                        cls = C_ILL;
    endcase
  end

  // A unit strobed last cycle may not have raised busy yet
  assign wt_free  = !wt_busy  && !wt_blk;
  assign mm_free  = !mm_busy  && !mm_blk;
  assign act_free = !act_busy && !act_blk;
  assign all_free = wt_free && mm_free && act_free;

  assign lab_busy = rst && ((state != IDLE) || !enable);

  // Delayed copy of each strobe, used as the busy-latency blackout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wt_blk  <= 1'b0;
      mm_blk  <= 1'b0;
      act_blk <= 1'b0;
    end else begin
      wt_blk  <= wt_en;
      mm_blk  <= mm_en;
      act_blk <= act_en;
    end
  end

  // Dispatch FSM with registered strobes, counters and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      held        <= INIT_INSTR;
      unit_instr  <= INIT_INSTR;
      wt_en       <= 1'b0;
      mm_en       <= 1'b0;
      act_en      <= 1'b0;
      illegal     <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      wt_en   <= 1'b0;
      mm_en   <= 1'b0;
      act_en  <= 1'b0;
      illegal <= 1'b0;
      if (enable) begin
        unique case (state)
          IDLE: begin
            if (lab_valid) begin
              held  <= lab_instr;
              state <= ISSUE;
            end
          end
          ISSUE: begin
            unique case (cls)
              C_WT: begin
                if (wt_free) begin
                  wt_en       <= 1'b1;
                  unit_instr  <= held;
                  retired_cnt <= retired_cnt + CNT_ONE;
                  state       <= IDLE;
                end
              end
              C_MM: begin
                if (mm_free && wt_free) begin
                  mm_en       <= 1'b1;
                  unit_instr  <= held;
                  retired_cnt <= retired_cnt + CNT_ONE;
                  state       <= IDLE;
                end
              end
              C_ACT: begin
                if (act_free && mm_free) begin
                  act_en      <= 1'b1;
                  unit_instr  <= held;
                  retired_cnt <= retired_cnt + CNT_ONE;
                  state       <= IDLE;
                end
              end
              C_NOP: begin
                retired_cnt <= retired_cnt + CNT_ONE;
                state       <= IDLE;
              end
              C_SYNC, C_HALT: begin
                state <= WAIT_ALL;
              end
              default: begin
                illegal     <= 1'b1;
                retired_cnt <= retired_cnt + CNT_ONE;
                state       <= IDLE;
              end
            endcase
          end
          WAIT_ALL: begin
            if (all_free) begin
              retired_cnt <= retired_cnt + CNT_ONE;
              if (cls == C_HALT) begin
                halted <= 1'b1;
                state  <= HALT;
              end else begin
                state <= IDLE;
              end
            end
          end
          HALT: begin
            halted <= 1'b1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_dispatcher.sv
// tb_instr_dispatcher: directed stimulus with a cycle-level reference
// model of dispatch rules, compared on every falling clock edge.
`timescale 1ns/1ps
module tb_instr_dispatcher;

  localparam int              CNT_W = 32;
  localparam int              IW    = 32;
  localparam logic [IW-1:0]   INIT  = '0;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b1;
  logic             lab_valid = 1'b0;
  logic [IW-1:0]    lab_instr = '0;
  logic             wt_force = 1'b0;
  logic             mm_force = 1'b0;
  logic             act_force = 1'b0;
  logic             auto_busy = 1'b0;
  logic [2:0]       wt_left = '0;
  logic [2:0]       mm_left = '0;
  logic [2:0]       act_left = '0;
  logic             wt_busy;
  logic             mm_busy;
  logic             act_busy;
  logic             lab_busy;
  logic             wt_en;
  logic             mm_en;
  logic             act_en;
  logic             halted;
  logic             illegal;
  logic [IW-1:0]    unit_instr;
  logic [CNT_W-1:0] retired_cnt;

  int errors = 0;
  int checks = 0;

  assign wt_busy  = wt_force  | (wt_left  != 0);
  assign mm_busy  = mm_force  | (mm_left  != 0);
  assign act_busy = act_force | (act_left != 0);

  always #5 clk = ~clk;

  instr_dispatcher #(.CNT_W(CNT_W), .INSTR_W(IW), .INIT_INSTR(INIT)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .lab_instr(lab_instr),
    .lab_valid(lab_valid),
    .lab_busy(lab_busy),
    .wt_busy(wt_busy),
    .mm_busy(mm_busy),
    .act_busy(act_busy),
    .wt_en(wt_en),
    .mm_en(mm_en),
    .act_en(act_en),
    .unit_instr(unit_instr),
    .halted(halted),
    .illegal(illegal),
    .retired_cnt(retired_cnt)
  );

  // Emulated units: busy rises the cycle after a strobe, lasts 3 cycles
  always @(posedge clk) begin
    if (!auto_busy) begin
      wt_left  <= '0;
      mm_left  <= '0;
      act_left <= '0;
    end else begin
      if (wt_en) wt_left <= 3'd3;
      else if (wt_left != 0) wt_left <= wt_left - 3'd1;
      if (mm_en) mm_left <= 3'd3;
      else if (mm_left != 0) mm_left <= mm_left - 3'd1;
      if (act_en) act_left <= 3'd3;
      else if (act_left != 0) act_left <= act_left - 3'd1;
    end
  end

  function automatic int op_class(input logic [7:0] o);
    if (o == 8'hFF) return 0;
    if (o == 8'h01) return 1;
    if (o == 8'h00) return 2;
    if (o[7]) return 3;
    if (o[7:5] == 3'b001) return 4;
    if (o[7:3] == 5'b00001) return 5;
    return 6;
  endfunction

  // Reference model: pending instruction, edge age since capture, history
  logic [IW-1:0]    m_held;
  logic [IW-1:0]    m_uinstr;
  logic [CNT_W-1:0] m_cnt;
  bit m_pend, m_halt;
  int m_age;
  bit m_wt, m_mm, m_act, m_ill;
  bit p_wt, p_mm, p_act;
  bit n_wt, n_mm, n_act, n_ill, n_ret;
  bit fw, fm, fa;
  int c;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_held = INIT; m_uinstr = INIT; m_cnt = '0;
      m_pend = 0; m_halt = 0; m_age = 0;
      m_wt = 0; m_mm = 0; m_act = 0; m_ill = 0;
      p_wt = 0; p_mm = 0; p_act = 0;
    end else begin
      n_wt = 0; n_mm = 0; n_act = 0; n_ill = 0; n_ret = 0;
      fw = !wt_busy && !p_wt;
      fm = !mm_busy && !p_mm;
      fa = !act_busy && !p_act;
      if (enable && !m_halt) begin
        if (!m_pend) begin
          if (lab_valid) begin
            m_pend = 1; m_age = 0; m_held = lab_instr;
          end
        end else begin
          m_age = m_age + 1;
          c = op_class(m_held[IW-1 -: 8]);
          case (c)
            3: n_wt = fw;
            4: n_mm = fw && fm;
            5: n_act = fa && fm;
            2: n_ret = 1;
            6: begin n_ill = 1; n_ret = 1; end
            default: begin
              if (m_age >= 2 && fw && fm && fa) begin
                n_ret = 1;
                if (c == 0) m_halt = 1;
              end
            end
          endcase
          if (n_wt || n_mm || n_act) begin
            n_ret = 1; m_uinstr = m_held;
          end
          if (n_ret) begin
            m_pend = 0; m_cnt = m_cnt + 1;
          end
        end
      end
      p_wt = m_wt; p_mm = m_mm; p_act = m_act;
      m_wt = n_wt; m_mm = n_mm; m_act = n_act; m_ill = n_ill;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("m_wt_en", 64'(wt_en), 64'(m_wt));
    chk("m_mm_en", 64'(mm_en), 64'(m_mm));
    chk("m_act_en", 64'(act_en), 64'(m_act));
    chk("m_illegal", 64'(illegal), 64'(m_ill));
    chk("m_halted", 64'(halted), 64'(m_halt));
    chk("m_cnt", 64'(retired_cnt), 64'(m_cnt));
    chk("m_uinstr", 64'(unit_instr), 64'(m_uinstr));
    chk("m_lab_busy", 64'(lab_busy),
        64'(rst && (m_pend || m_halt || !enable)));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [IW-1:0] i);
    int n;
    n = 0;
    while (lab_busy && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
    lab_instr = i;
    lab_valid = 1'b1;
    tick();
    lab_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    tick(2);
    chk("rst_lab_busy", 64'(lab_busy), 64'(0));
    chk("rst_wt_en", 64'(wt_en), 64'(0));
    chk("rst_halted", 64'(halted), 64'(0));
    chk("rst_cnt", 64'(retired_cnt), 64'(0));
    chk("rst_uinstr", 64'(unit_instr), 64'(INIT));
    rst = 1'b1;
    tick(2);

    send(32'h080000AA);
    chk("t1_busy", 64'(lab_busy), 64'(1));
    chk("t1_early", 64'(act_en), 64'(0));
    tick();
    chk("t1_act", 64'(act_en), 64'(1));
    chk("t1_uinstr", 64'(unit_instr), 64'(32'h080000AA));
    chk("t1_cnt", 64'(retired_cnt), 64'(1));
    tick();
    chk("t1_pulse", 64'(act_en), 64'(0));
    chk("t1_hold", 64'(unit_instr), 64'(32'h080000AA));
    tick(2);

    wt_force = 1'b1;
    send(32'h20000011);
    repeat (3) begin
      tick();
      chk("t2_held_off", 64'(mm_en), 64'(0));
      chk("t2_busy", 64'(lab_busy), 64'(1));
    end
    wt_force = 1'b0;
    tick();
    chk("t2_mm", 64'(mm_en), 64'(1));
    chk("t2_cnt", 64'(retired_cnt), 64'(2));
    tick(3);

    send(32'h80000001);
    tick();
    chk("t3a_first", 64'(wt_en), 64'(1));
    send(32'h80000002);
    tick();
    chk("t3a_blackout", 64'(wt_en), 64'(0));
    tick();
    chk("t3a_second", 64'(wt_en), 64'(1));
    chk("t3a_uinstr", 64'(unit_instr), 64'(32'h80000002));
    chk("t3a_cnt", 64'(retired_cnt), 64'(4));
    tick(3);

    auto_busy = 1'b1;
    send(32'h80000003);
    tick();
    chk("t3b_first", 64'(wt_en), 64'(1));
    send(32'h80000004);
    n = 0;
    do begin
      tick();
      n++;
    end while (!wt_en && n < 20);
    chk("t3b_latency", 64'(n), 64'(4));
    chk("t3b_busy_low", 64'(wt_busy), 64'(0));
    tick(4);
    auto_busy = 1'b0;
    tick(3);

    mm_force = 1'b1;
    act_force = 1'b1;
    send(32'h01000000);
    tick(3);
    chk("t4_wait_busy", 64'(lab_busy), 64'(1));
    mm_force = 1'b0;
    tick(2);
    chk("t4_wait_act", 64'(lab_busy), 64'(1));
    chk("t4_cnt_hold", 64'(retired_cnt), 64'(6));
    act_force = 1'b0;
    tick();
    chk("t4_done", 64'(lab_busy), 64'(0));
    chk("t4_cnt", 64'(retired_cnt), 64'(7));

    send(32'h00000000);
    tick();
    chk("nop_cnt", 64'(retired_cnt), 64'(8));

    wt_force = 1'b1;
    send(32'h20000055);
    tick(2);
    chk("t7_blocked", 64'(mm_en), 64'(0));
    enable = 1'b0;
    wt_force = 1'b0;
    tick(3);
    chk("t7_frozen", 64'(mm_en), 64'(0));
    chk("t7_cnt", 64'(retired_cnt), 64'(8));
    enable = 1'b1;
    tick();
    chk("t7_resume", 64'(mm_en), 64'(1));
    chk("t7_uinstr", 64'(unit_instr), 64'(32'h20000055));
    tick(2);

    send(32'h42000000);
    tick();
    chk("t5_illegal", 64'(illegal), 64'(1));
    chk("t5_ill_cnt", 64'(retired_cnt), 64'(10));
    tick();
    chk("t5_ill_pulse", 64'(illegal), 64'(0));
    send(32'hFF000000);
    tick();
    chk("t5_not_yet", 64'(halted), 64'(0));
    tick();
    chk("t5_halted", 64'(halted), 64'(1));
    chk("t5_halt_cnt", 64'(retired_cnt), 64'(11));
    lab_instr = 32'h80000009;
    lab_valid = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (wt_en) seen++;
    end
    chk("t5_ignored", 64'(seen), 64'(0));
    chk("t5_busy", 64'(lab_busy), 64'(1));
    lab_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_rst_halted", 64'(halted), 64'(0));
    chk("t5_rst_cnt", 64'(retired_cnt), 64'(0));
    tick();
    rst = 1'b1;
    tick(2);

    wt_force = 1'b1;
    send(32'h80000077);
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_lab_busy", 64'(lab_busy), 64'(0));
    chk("t6_uinstr", 64'(unit_instr), 64'(INIT));
    chk("t6_cnt", 64'(retired_cnt), 64'(0));
    tick(2);
    rst = 1'b1;
    wt_force = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (wt_en) seen++;
    end
    chk("t6_no_wt_en", 64'(seen), 64'(0));
    chk("t6_cnt_after", 64'(retired_cnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
INSTR_DISPATCHER -- requirements
Module: instr_dispatcher

Interface
REQ-001 Parameter: CNT_W, 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active-low.
REQ-004 enable  input  1  dispatcher runs when 1; holds all state when 0, with unit enables forced to 0.
REQ-005 lab_instr  input  instr_type  head instruction from the look-ahead buffer.
REQ-006 lab_valid  input  1  lab_instr is valid.
REQ-007 lab_busy  output  1  to the buffer; 1 = do not present or advance the next instruction.
REQ-008 wt_busy, mm_busy, act_busy  input  1 each  weight-load, matrix-multiply and activation unit busy.
REQ-009 wt_en, mm_en, act_en  output  1 each  single-cycle issue strobe per unit.
REQ-010 unit_instr  output  instr_type  instruction held for the unit strobed this cycle.
REQ-011 halted  output  1  HALT retired; sticky until reset.
REQ-012 illegal  output  1  one-cycle pulse on an undecodable opcode.
REQ-013 retired_cnt  output  CNT_W  count of issued plus dropped instructions.

Function
REQ-014 Opcode decode, in priority order: 8'hFF HALT; 8'h01 SYNC; 8'h00 NOP; opcode[7]=1 WEIGHT; opcode[7:5]=3'b001 MATRIX; opcode[7:3]=5'b00001 ACT; all others ILLEGAL.
REQ-015 FSM states: IDLE, ISSUE, WAIT_ALL, HALT.
REQ-016 IDLE: when enable=1 and lab_valid=1, capture lab_instr into a holding register, then go to ISSUE.
REQ-017 lab_busy SHALL be 1 in every state except IDLE and SHALL be 1 whenever enable=0.
REQ-018 Unit availability: a unit is free when its busy input is 0 and no issue strobe went to it in the previous cycle (one-cycle blackout covering unit busy-rise latency).
REQ-019 ISSUE, WEIGHT: wait until the weight unit is free, then strobe wt_en.
REQ-020 ISSUE, MATRIX: wait until both the matrix and weight units are free, then strobe mm_en.
REQ-021 ISSUE, ACT: wait until both the activation and matrix units are free, then strobe act_en.
REQ-022 Each strobe is exactly one cycle, with unit_instr equal to the held instruction; the FSM returns to IDLE in the same edge.
REQ-023 ISSUE, NOP: retire with no strobe and return to IDLE.
REQ-024 ISSUE, ILLEGAL: pulse illegal for one cycle, retire with no strobe, and return to IDLE.
REQ-025 ISSUE, SYNC or HALT: go to WAIT_ALL.
REQ-026 WAIT_ALL: wait until all three units are free; then retire a SYNC and go to IDLE, or retire a HALT and go to HALT.
REQ-027 HALT: set halted=1, keep lab_busy=1, issue no strobes and ignore lab_valid; only reset exits.
REQ-028 Minimum issue latency: strobe at the 2nd edge after lab_valid is sampled; peak throughput is one instruction per 2 cycles.
REQ-029 At most one unit strobe per cycle.
REQ-030 unit_instr holds its last value when no strobe is active.
REQ-031 retired_cnt increments by 1 on each retire and wraps modulo 2^CNT_W with no flag.
REQ-032 enable=0 mid-wait: the FSM and holding register freeze, no strobe, no count change; operation resumes unchanged when enable returns to 1.
REQ-033 A busy input rising in the same cycle the wait condition would pass SHALL block the issue.

Reset
REQ-034 While rst=0, the next state is immediately IDLE, as is the state on release.
REQ-035 Reset values: all *_en=0, illegal=0, halted=0, lab_busy=0, retired_cnt=0, unit_instr=INIT_INSTR, blackout bits cleared.
REQ-036 Reset mid-wait discards the held instruction; no strobe is issued for it.

Verification
REQ-037 Opcode 8'b00001000 with all units idle -> act_en=1 exactly 2 edges after capture; retired_cnt 0->1.
REQ-038 Opcode 8'b00100000 while wt_busy=1 for 4 cycles -> mm_en is held off until the first cycle after wt_busy falls; lab_busy=1 throughout.
REQ-039 Back-to-back 8'h80 then 8'h80, with units raising busy one cycle after en -> the second wt_en is not issued in the blackout cycle and is issued only after wt_busy=0.
REQ-040 8'h01 (SYNC) while mm_busy=1 and act_busy=1 -> no strobe and lab_busy=1 until both are 0; then IDLE and retired_cnt+1.
REQ-041 8'h42, then 8'hFF -> illegal pulses once; then halted=1, lab_busy=1, and later lab_valid is ignored until rst is pulsed low.
REQ-042 rst asserted low while in ISSUE waiting on wt_busy -> all outputs return to reset values with no clock edge, and no wt_en is issued after release.
